spi_bus_bridge: RTL and testbench

SPI target front-end for the Levenshtein engine. It recovers SPI frames from the host pins (SS, SCK, MOSI, MISO, carried on ui_in[4..6] and uo_out[7]) and turns them into byte-wide bus read and write transactions. The engine's register file and the external PMOD SRAM arbiter sit downstream on that bus. All SPI inputs are oversampled in the system clock domain; there is no SCK clock domain.

---
 rtl/spi_bus_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_bus_bridge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_bus_bridge                                                             |
// | Oversampled SPI mode-0 target that turns frames into byte-wide bus cycles. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_bus_bridge #(
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_ss_n,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  bus_cyc,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_adr,
    output logic [7:0]            bus_dat_w,
    input  logic [7:0]            bus_dat_r,
    input  logic                  bus_ack,
    output logic                  overrun
);

    typedef logic [2:0] state_t;
    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_cmd   = 3'd1;
    localparam state_t c_st_addr  = 3'd2;
    localparam state_t c_st_dummy = 3'd3;
    localparam state_t c_st_data  = 3'd4;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_ss_sync, r_sck_sync, r_mosi_sync;
    logic                  r_ss_d, r_sck_d;
    logic [2:0]            r_bit_cnt;
    logic [1:0]            r_addr_cnt;
    logic [6:0]            r_sh_in;
    logic [7:0]            r_sh_out;
    logic [15:0]           r_addr_hi;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_is_wr;
    logic [7:0]            r_pf;
    logic                  r_pf_valid;
    logic                  r_overrun;
    logic                  r_cyc, r_we, r_discard;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [7:0]            r_dat_w;
    logic                  r_pend, r_pend_we;
    logic [ADDR_WIDTH-1:0] r_pend_adr;
    logic [7:0]            r_pend_dat;

    logic                  w_ss, w_sck, w_mosi;
    logic                  w_ss_fall, w_ss_rise, w_rise, w_fall;
    logic [7:0]            w_byte;
    logic                  w_byte_done, w_addr_last, w_load;
    logic [23:0]           w_addr_new;
    logic                  w_req, w_req_we;
    logic [ADDR_WIDTH-1:0] w_req_adr;
    logic                  w_issue, w_pend_new, w_drop, w_pend_issue;

    assign w_ss        = r_ss_sync[1];
    assign w_sck       = r_sck_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_ss_fall   = r_ss_d & ~w_ss;
    assign w_ss_rise   = ~r_ss_d & w_ss;
    assign w_rise      = w_sck & ~r_sck_d & ~w_ss;
    assign w_fall      = ~w_sck & r_sck_d & ~w_ss;
    assign w_byte      = {r_sh_in, w_mosi};
    assign w_byte_done = w_rise && (r_bit_cnt == 3'd7) && (r_state != c_st_idle);
    assign w_addr_last = w_byte_done && (r_state == c_st_addr) && (r_addr_cnt == 2'd2);
    assign w_addr_new  = {r_addr_hi, w_byte};
    assign w_load      = w_fall && (r_state == c_st_data) && !r_is_wr && (r_bit_cnt == 3'd0);

    // A pending slot lets a new frame queue one request behind a discarded one.
    assign w_issue      = w_req && !r_cyc && !r_pend;
    assign w_pend_new   = w_req && r_cyc && r_discard && !r_pend;
    assign w_drop       = w_req && !w_issue && !w_pend_new;
    assign w_pend_issue = r_pend && !r_cyc && !w_ss;

    always_comb begin
        w_state_nxt = r_state;
        if (w_ss) begin
            w_state_nxt = c_st_idle;
        end else if (w_ss_fall) begin
            w_state_nxt = c_st_cmd;
        end else if (w_byte_done) begin
            case (r_state)
                c_st_cmd:   w_state_nxt = c_st_addr;
                c_st_addr:  if (r_addr_cnt == 2'd2) w_state_nxt = r_is_wr ? c_st_data : c_st_dummy;
                c_st_dummy: w_state_nxt = c_st_data;
                default:    w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_req     = 1'b0;
        w_req_we  = 1'b0;
        w_req_adr = r_addr;
        if (w_byte_done && (r_state == c_st_data) && r_is_wr) begin
            w_req    = 1'b1;
            w_req_we = 1'b1;
        end else if (w_addr_last && !r_is_wr) begin
            w_req     = 1'b1;
            w_req_adr = w_addr_new[ADDR_WIDTH-1:0];
        end else if (w_load) begin
            w_req = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // SS sync resets low so a select held across reset is not seen as a new frame.
            r_ss_sync   <= 2'b00;
            r_sck_sync  <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_ss_d      <= 1'b0;
            r_sck_d     <= 1'b0;
            r_state     <= c_st_idle;
        end else begin
            r_ss_sync   <= {r_ss_sync[0], spi_ss_n};
            r_sck_sync  <= {r_sck_sync[0], spi_sck};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
            r_ss_d      <= w_ss;
            r_sck_d     <= w_sck;
            r_state     <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_addr_cnt <= '0;
            r_sh_in    <= '0;
            r_sh_out   <= '0;
            r_addr_hi  <= '0;
            r_addr     <= '0;
            r_is_wr    <= 1'b0;
            r_pf       <= '0;
            r_pf_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_discard  <= 1'b0;
            r_adr      <= '0;
            r_dat_w    <= '0;
            r_pend     <= 1'b0;
            r_pend_we  <= 1'b0;
            r_pend_adr <= '0;
            r_pend_dat <= '0;
        end else begin
            if (w_ss_fall) begin
                r_bit_cnt  <= '0;
                r_addr_cnt <= '0;
                r_overrun  <= 1'b0;
                r_pf_valid <= 1'b0;
                r_sh_out   <= '0;
            end else if (w_rise && (r_state != c_st_idle)) begin
                r_sh_in   <= w_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done && (r_state == c_st_cmd)) r_is_wr <= w_byte[7];
            if (w_byte_done && (r_state == c_st_addr)) begin
                r_addr_hi  <= {r_addr_hi[7:0], w_byte};
                r_addr_cnt <= r_addr_cnt + 2'd1;
                if (w_addr_last) r_addr <= w_addr_new[ADDR_WIDTH-1:0];
            end

            if (w_load) begin
                r_sh_out   <= r_pf_valid ? r_pf : 8'hFF;
                r_pf_valid <= 1'b0;
                if (!r_pf_valid) r_overrun <= 1'b1;
            end else if (w_fall && (r_state == c_st_data)) begin
                r_sh_out <= {r_sh_out[6:0], 1'b0};
            end
            if (w_drop && w_req_we) r_overrun <= 1'b1;

            if (r_cyc && bus_ack) begin
                r_cyc     <= 1'b0;
                r_discard <= 1'b0;
                if (!r_discard && !r_we) begin
                    r_pf       <= bus_dat_r;
                    r_pf_valid <= 1'b1;
                    r_addr     <= r_addr + ADDR_WIDTH'(1);
                end
            end else if (w_ss_rise && r_cyc) begin
                r_discard <= 1'b1;
            end

            if (w_issue) begin
                r_cyc <= 1'b1;
                r_we  <= w_req_we;
                r_adr <= w_req_adr;
                if (w_req_we) r_dat_w <= w_byte;
            end else if (w_pend_issue) begin
                r_cyc   <= 1'b1;
                r_we    <= r_pend_we;
                r_adr   <= r_pend_adr;
                r_dat_w <= r_pend_dat;
                r_pend  <= 1'b0;
            end
            if (w_pend_new) begin
                r_pend     <= 1'b1;
                r_pend_we  <= w_req_we;
                r_pend_adr <= w_req_adr;
                r_pend_dat <= w_byte;
            end
            if (w_req_we && (w_issue || w_pend_new)) r_addr <= r_addr + ADDR_WIDTH'(1);
            if (w_ss_rise) r_pend <= 1'b0;
        end
    end

    assign spi_miso  = r_sh_out[7] & ~w_ss & ((r_state == c_st_dummy) || (r_state == c_st_data));
    assign bus_cyc   = r_cyc;
    assign bus_we    = r_we;
    assign bus_adr   = r_adr;
    assign bus_dat_w = r_dat_w;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_bus_bridge                                                          |
// | Directed plus randomized frames against a memory-backed reference model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_spi_bus_bridge;

    localparam int c_half = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_ss_n, spi_sck, spi_mosi, spi_miso;
    logic        bus_cyc, bus_we, bus_ack, overrun;
    logic [23:0] bus_adr;
    logic [7:0]  bus_dat_w, bus_dat_r;

    int vectors     = 0;
    int miscompares = 0;
    int ack_lat     = 1;
    int wait_cnt    = 0;

    logic [7:0]  mem [int];
    logic        log_we  [$];
    logic [23:0] log_adr [$];
    logic [7:0]  log_dat [$];
    logic [7:0]  tx_d [4];
    logic [7:0]  rx_d [4];

    spi_bus_bridge #(.ADDR_WIDTH(24)) dut (
        .clk(clk), .rst(rst),
        .spi_ss_n(spi_ss_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_adr(bus_adr), .bus_dat_w(bus_dat_w),
        .bus_dat_r(bus_dat_r), .bus_ack(bus_ack), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[7:0] ^ a[15:8] ^ 8'h69;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_we.delete();
        log_adr.delete();
        log_dat.delete();
    endtask

    // Bus target: acks after ack_lat extra cycles and records each completed cycle.
    initial begin
        bus_ack   = 1'b0;
        bus_dat_r = 8'h00;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_cyc && !rst) begin
                if (wait_cnt >= ack_lat) begin
                    wait_cnt = 0;
                    bus_ack  = 1'b1;
                    if (bus_we) mem[int'(bus_adr)] = bus_dat_w;
                    else bus_dat_r = mem_rd(bus_adr);
                    log_we.push_back(bus_we);
                    log_adr.push_back(bus_adr);
                    log_dat.push_back(bus_we ? bus_dat_w : bus_dat_r);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic spi_bits(input logic [7:0] tx, input int nb, input logic end_frame,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nb; i++) begin
            spi_mosi = tx[7-i];
            wait_clk(c_half);
            rx[7-i] = spi_miso;
            spi_sck = 1'b1;
            wait_clk(c_half);
            spi_sck = 1'b0;
            if (end_frame && (i == nb - 1)) spi_ss_n = 1'b1;
        end
    endtask

    task automatic run_frame(input logic wr, input logic [23:0] a, input int n);
        logic [7:0] rx;
        spi_ss_n = 1'b0;
        wait_clk(c_half);
        spi_bits({wr, 7'($urandom)}, 8, 1'b0, rx);
        spi_bits(a[23:16], 8, 1'b0, rx);
        spi_bits(a[15:8], 8, 1'b0, rx);
        spi_bits(a[7:0], 8, 1'b0, rx);
        if (!wr) spi_bits(8'h00, 8, 1'b0, rx);
        for (int i = 0; i < n; i++) begin
            spi_bits(tx_d[i], 8, i == n - 1, rx);
            rx_d[i] = rx;
        end
        wait_clk(8);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus_cyc && t < 600) begin
            wait_clk(1);
            t++;
        end
        wait_clk(2);
        check("bus idle", 32'(bus_cyc), 32'd0);
    endtask

    // Expected bus traffic: writes at a+i of tx_d[i]; reads at a..a+n (one prefetch ahead).
    task automatic test_frame(input string tag, input logic wr, input logic [23:0] a, input int n);
        logic [7:0]  exp_d [4];
        logic [23:0] ea;
        for (int i = 0; i < n; i++) exp_d[i] = wr ? tx_d[i] : mem_rd(a + 24'(i));
        clear_log();
        run_frame(wr, a, n);
        wait_idle();
        check({tag, " count"}, 32'(log_adr.size()), wr ? 32'(n) : 32'(n + 1));
        for (int i = 0; i < log_adr.size(); i++) begin
            ea = a + 24'(i);
            check({tag, " we"}, 32'(log_we[i]), 32'(wr));
            check({tag, " adr"}, 32'(log_adr[i]), 32'(ea));
            if (wr && i < n) check({tag, " dat"}, 32'(log_dat[i]), 32'(exp_d[i]));
        end
        if (!wr) begin
            for (int i = 0; i < n; i++) check({tag, " miso"}, 32'(rx_d[i]), 32'(exp_d[i]));
        end
        check({tag, " overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  rx;
        logic        wr;
        logic [23:0] a;
        int          n;

        rst = 1'b1;
        spi_ss_n = 1'b1;
        spi_sck = 1'b0;
        spi_mosi = 1'b0;
        wait_clk(3);
        check("reset miso", 32'(spi_miso), 32'd0);
        check("reset cyc", 32'(bus_cyc), 32'd0);
        check("reset we", 32'(bus_we), 32'd0);
        check("reset adr", 32'(bus_adr), 32'd0);
        check("reset dat_w", 32'(bus_dat_w), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        wait_clk(4);

        ack_lat = 1;
        tx_d[0] = 8'hA5; tx_d[1] = 8'h5A;
        test_frame("write", 1'b1, 24'h000100, 2);

        mem[16] = 8'h3C; mem[17] = 8'hC3;
        test_frame("read", 1'b0, 24'h000010, 2);

        tx_d[0] = 8'h81; tx_d[1] = 8'h7E;
        test_frame("wrap", 1'b1, 24'hFFFFFF, 2);

        // Write overrun: second byte completes while the first write is unacked.
        ack_lat = 100;
        tx_d[0] = 8'h11; tx_d[1] = 8'h22;
        clear_log();
        run_frame(1'b1, 24'h000400, 2);
        check("wr ovr flag", 32'(overrun), 32'd1);
        wait_idle();
        check("wr ovr count", 32'(log_adr.size()), 32'd1);
        if (log_adr.size() > 0) begin
            check("wr ovr adr", 32'(log_adr[0]), 32'h400);
            check("wr ovr dat", 32'(log_dat[0]), 32'h11);
        end

        // Slow bus read: the first data byte finds no prefetch.
        tx_d[0] = 8'h00;
        run_frame(1'b0, 24'h000020, 1);
        check("slow miso", 32'(rx_d[0]), 32'hFF);
        check("slow overrun", 32'(overrun), 32'd1);
        wait_idle();
        spi_ss_n = 1'b0;
        wait_clk(c_half);
        check("ss clears ovr", 32'(overrun), 32'd0);
        spi_ss_n = 1'b1;
        wait_clk(8);

        // Abort: SS rises after 3 bits of a data byte.
        ack_lat = 1;
        clear_log();
        spi_ss_n = 1'b0;
        wait_clk(c_half);
        spi_bits(8'h80, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        spi_bits(8'h03, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        spi_bits(8'hFF, 3, 1'b1, rx);
        wait_clk(8);
        wait_idle();
        check("abort count", 32'(log_adr.size()), 32'd0);
        check("abort miso", 32'(spi_miso), 32'd0);
        tx_d[0] = 8'h3A;
        test_frame("after abort", 1'b1, 24'h000300, 1);

        // Reset mid-frame while a discarded write is still outstanding.
        ack_lat = 400;
        clear_log();
        tx_d[0] = 8'h77;
        run_frame(1'b1, 24'h000200, 1);
        spi_ss_n = 1'b0;
        wait_clk(c_half);
        spi_bits(8'h80, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        check("rst pre cyc", 32'(bus_cyc), 32'd1);
        rst = 1'b1;
        wait_clk(1);
        check("rst mid cyc", 32'(bus_cyc), 32'd0);
        check("rst mid we", 32'(bus_we), 32'd0);
        check("rst mid adr", 32'(bus_adr), 32'd0);
        check("rst mid dat_w", 32'(bus_dat_w), 32'd0);
        check("rst mid miso", 32'(spi_miso), 32'd0);
        check("rst mid overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        spi_bits(8'h02, 8, 1'b0, rx);
        spi_bits(8'h10, 8, 1'b0, rx);
        spi_bits(8'h99, 8, 1'b1, rx);
        wait_clk(8);
        wait_idle();
        check("rst ignored count", 32'(log_adr.size()), 32'd0);
        ack_lat = 1;

        for (int k = 0; k < 8; k++) begin
            wr = 1'($urandom_range(0, 1));
            a  = (k == 3 || k == 6) ? 24'hFFFFFE : 24'($urandom);
            n  = $urandom_range(1, 3);
            ack_lat = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) tx_d[i] = 8'($urandom);
            test_frame(wr ? "rand write" : "rand read", wr, a, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
